// File: rtl/aes_round_ctrl_if.sv
// Host-side bundle for the AES round controller: plaintext/key in, ciphertext out.
// Latency: none (wires only).
// Backpressure: valid/ready on both directions; master drives in_* and out_ready.
interface aes_round_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;

    modport master (
        output in_valid, in_block, in_key, out_ready,
        input  in_ready, out_valid, out_block
    );

    modport slave (
        input  in_valid, in_block, in_key, out_ready,
        output in_ready, out_valid, out_block
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: owns state/key registers, round counter and Rcon; optional abort via AES_CTRL_ABORT_EN.
// Latency: out_valid rises NR+1 cycles after the accepting cycle; next accept NR+2 cycles after the previous one.
// Backpressure: in_ready only in IDLE; ciphertext held stable in DONE until out_ready.
module aes_round_ctrl #(
    parameter int NR    = 10,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    aes_round_ctrl_if.slave  host,
    output logic [127:0]     rnd_block_o,
    output logic [127:0]     rnd_key_o,
    output logic             rnd_final_o,
    input  logic [127:0]     rnd_result_i,
    output logic [127:0]     kexp_key_o,
    output logic [7:0]       kexp_rcon_o,
    input  logic [127:0]     kexp_next_i,
`ifdef AES_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [127:0]       state_reg;
    logic [127:0]       key_reg;
    logic [CNT_W-1:0]   rnd_cnt;
    logic [7:0]         rcon_reg;

    logic               load;
    logic               step;
    logic               clr;
    logic               last;

    // Multiply by x in GF(2^8): next Rcon byte
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    assign last = (rnd_cnt == CNT_W'(NR));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and register-update strobes
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        clr       = 1'b0;
        case (state)
            IDLE: begin
                if (host.in_valid) begin
                    load      = 1'b1;
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (host.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
`ifdef AES_CTRL_ABORT_EN
        // Abort wins over round progress and over out_ready; IDLE ignores it
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
            step      = 1'b0;
            clr       = 1'b1;
        end
`endif
    end

    // Datapath registers: load on accept, advance one round per ROUND cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= '0;
            key_reg   <= '0;
            rnd_cnt   <= '0;
            rcon_reg  <= 8'h01;
        end else if (load) begin
            state_reg <= host.in_block ^ host.in_key;
            key_reg   <= host.in_key;
            rnd_cnt   <= CNT_W'(1);
            rcon_reg  <= 8'h01;
        end else if (clr) begin
            state_reg <= '0;
            rnd_cnt   <= '0;
        end else if (step) begin
            state_reg <= rnd_result_i;
            key_reg   <= kexp_next_i;
            rnd_cnt   <= rnd_cnt + CNT_W'(1);
            rcon_reg  <= xtime(rcon_reg);
        end
    end

    // Handshake flags depend on state only, so no in_valid -> in_ready path exists
    assign host.in_ready  = (state == IDLE);
    assign host.out_valid = (state == DONE);
    assign host.out_block = state_reg;
    assign busy           = (state == ROUND);

    assign rnd_block_o    = state_reg;
    assign rnd_key_o      = kexp_next_i;
    assign rnd_final_o    = (state == ROUND) && last;
    assign kexp_key_o     = key_reg;
    assign kexp_rcon_o    = rcon_reg;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: golden round/key-expand models close the datapath loop.
// Latency: checks out_valid appears exactly NR+1 cycles after the accepting cycle.
// Backpressure: stalls out_ready and drives in_valid during rounds to check holding.
module tb_aes_round_ctrl;
    localparam int NR = 10;

    localparam logic [127:0] APPB_PT = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] APPB_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] APPB_CT = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_K    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] rnd_block_o, rnd_key_o, rnd_result_i;
    logic [127:0] kexp_key_o, kexp_next_i;
    logic [7:0]   kexp_rcon_o;
    logic         rnd_final_o;
    logic         busy;
`ifdef AES_CTRL_ABORT_EN
    logic         abort;
`endif

    int           n_chk = 0;
    int           n_err = 0;
    int           cyc   = 0;
    int           acc_q[$];
    logic [127:0] out_q[$];
    logic [7:0]   sbox [256];

    aes_round_ctrl_if ifc ();

    aes_round_ctrl #(.NR(NR), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host         (ifc),
        .rnd_block_o  (rnd_block_o),
        .rnd_key_o    (rnd_key_o),
        .rnd_final_o  (rnd_final_o),
        .rnd_result_i (rnd_result_i),
        .kexp_key_o   (kexp_key_o),
        .kexp_rcon_o  (kexp_rcon_o),
        .kexp_next_i  (kexp_next_i),
`ifdef AES_CTRL_ABORT_EN
        .abort        (abort),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    task automatic init_sbox();
        logic [7:0] inv, b, r;
        for (int i = 0; i < 256; i++) begin
            inv = 8'h00;
            for (int j = 1; j < 256; j++)
                if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
            b = inv;
            r = b ^ rotl1(b) ^ rotl1(rotl1(b)) ^ rotl1(rotl1(rotl1(b)))
                ^ rotl1(rotl1(rotl1(rotl1(b)))) ^ 8'h63;
            sbox[i] = r;
        end
    endtask

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox[s[127-8*i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
            o[103-32*c -: 8] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
        end
        return o;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k,
                                              input logic fin);
        logic [127:0] t;
        t = shift_rows(sub_bytes(s));
        if (!fin) t = mix_cols(t);
        return t ^ k;
    endfunction

    // Whole-cipher reference: full key schedule first, then the ten rounds
    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   rcon [10];
        logic [31:0]  t;
        logic [127:0] s;
        rcon[0] = 8'h01;
        for (int i = 1; i < 10; i++) rcon[i] = xt(rcon[i-1]);
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon[i/4-1], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        s = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= 10; r++) begin
            s = shift_rows(sub_bytes(s));
            if (r < 10) s = mix_cols(s);
            s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return s;
    endfunction

    // Golden key-expand datapath
    always_comb kexp_next_i = key_step(kexp_key_o, kexp_rcon_o);

    // Golden round datapath
    always_comb rnd_result_i = round_fn(rnd_block_o, rnd_key_o, rnd_final_o);

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Handshake monitor: records accept cycles and delivered ciphertexts
    always @(negedge clk) begin
        #2;
        cyc++;
        if (rst_n && ifc.in_valid && ifc.in_ready) acc_q.push_back(cyc);
        if (rst_n && ifc.out_valid && ifc.out_ready) out_q.push_back(ifc.out_block);
    end

    // Offer a pair at the current negedge; returns at the negedge of round 1
    task automatic send(input logic [127:0] pt, input logic [127:0] key);
        int n = 0;
        ifc.in_valid = 1'b1;
        ifc.in_block = pt;
        ifc.in_key   = key;
        #1;
        while (ifc.in_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("accept_wait", 128'(n < 64), 128'd1);
        @(negedge clk);
        ifc.in_valid = 1'b0;
    endtask

    task automatic txn(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] exp,
                       input int stall, input bit junk, input string tag);
        logic [127:0] held;
        logic [7:0]   rc;
        int           acc0, out0;
        @(negedge clk);
        acc0 = acc_q.size();
        out0 = out_q.size();
        ifc.out_ready = 1'b0;
        send(pt, key);
        rc = 8'h01;
        for (int r = 1; r <= NR; r++) begin
            if (junk) begin
                ifc.in_valid = 1'b1;
                ifc.in_block = {$urandom, $urandom, $urandom, $urandom};
            end
            #1;
            check({tag, ":busy"},      128'(busy),          128'd1);
            check({tag, ":in_ready"},  128'(ifc.in_ready),  128'd0);
            check({tag, ":early_vld"}, 128'(ifc.out_valid), 128'd0);
            check({tag, ":final"},     128'(rnd_final_o),   128'(r == NR));
            check({tag, ":rcon"},      128'(kexp_rcon_o),   128'(rc));
            rc = xt(rc);
            @(negedge clk);
        end
        ifc.in_valid = 1'b0;
        #1;
        check({tag, ":out_valid"}, 128'(ifc.out_valid), 128'd1);
        check({tag, ":out_block"}, ifc.out_block,       exp);
        check({tag, ":done_busy"}, 128'(busy),          128'd0);
        held = ifc.out_block;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            #1;
            check({tag, ":hold_vld"}, 128'(ifc.out_valid), 128'd1);
            check({tag, ":hold_blk"}, ifc.out_block,       held);
            check({tag, ":hold_rdy"}, 128'(ifc.in_ready),  128'd0);
        end
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        #1;
        check({tag, ":idle_rdy"}, 128'(ifc.in_ready),  128'd1);
        check({tag, ":idle_vld"}, 128'(ifc.out_valid), 128'd0);
        check({tag, ":n_accept"}, 128'(acc_q.size()),  128'(acc0 + 1));
        check({tag, ":n_out"},    128'(out_q.size()),  128'(out0 + 1));
        if (out_q.size() > 0) check({tag, ":delivered"}, out_q[$], exp);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, o0, n;
        logic [127:0] pt, key;
        rst_n         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_block  = '0;
        ifc.in_key    = '0;
        ifc.out_ready = 1'b0;
`ifdef AES_CTRL_ABORT_EN
        abort         = 1'b0;
`endif
        init_sbox();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst:in_ready",  128'(ifc.in_ready),  128'd1);
        check("rst:out_valid", 128'(ifc.out_valid), 128'd0);
        check("rst:busy",      128'(busy),          128'd0);
        check("rst:out_block", ifc.out_block,       128'd0);
        check("rst:rcon",      128'(kexp_rcon_o),   128'h01);
        check("rst:final",     128'(rnd_final_o),   128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Known-answer vectors; C.1 also exercises backpressure and ignored input
        txn(APPB_PT, APPB_K, APPB_CT, 0, 1'b0, "appb");
        txn(C1_PT,   C1_K,   C1_CT,   5, 1'b1, "c1");

        // Back-to-back with in_valid held and out_ready high
        @(negedge clk);
        a0 = acc_q.size();
        o0 = out_q.size();
        ifc.out_ready = 1'b1;
        ifc.in_valid  = 1'b1;
        ifc.in_block  = APPB_PT;
        ifc.in_key    = APPB_K;
        n = 0;
        while (acc_q.size() < a0 + 1 && n < 50) begin @(negedge clk); n++; end
        ifc.in_block = C1_PT;
        ifc.in_key   = C1_K;
        n = 0;
        while (acc_q.size() < a0 + 2 && n < 50) begin @(negedge clk); n++; end
        ifc.in_valid = 1'b0;
        n = 0;
        while (out_q.size() < o0 + 2 && n < 50) begin @(negedge clk); n++; end
        ifc.out_ready = 1'b0;
        check("b2b:n_accept", 128'(acc_q.size()), 128'(a0 + 2));
        check("b2b:n_out",    128'(out_q.size()), 128'(o0 + 2));
        if (acc_q.size() >= a0 + 2) check("b2b:interval", 128'(acc_q[a0+1] - acc_q[a0]), 128'd12);
        if (out_q.size() >= o0 + 2) begin
            check("b2b:first",  out_q[o0],   APPB_CT);
            check("b2b:second", out_q[o0+1], C1_CT);
        end

        // Async reset in round 5
        @(negedge clk);
        send(APPB_PT, APPB_K);
        repeat (4) @(negedge clk);
        #1;
        check("rst5:busy_before", 128'(busy), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst5:in_ready",  128'(ifc.in_ready),  128'd1);
        check("rst5:busy",      128'(busy),          128'd0);
        check("rst5:out_valid", 128'(ifc.out_valid), 128'd0);
        check("rst5:out_block", ifc.out_block,       128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        o0 = out_q.size();
        ifc.out_ready = 1'b1;
        repeat (14) @(negedge clk);
        ifc.out_ready = 1'b0;
        check("rst5:no_out", 128'(out_q.size()), 128'(o0));
        txn(APPB_PT, APPB_K, APPB_CT, 1, 1'b0, "rst5_appb");

`ifdef AES_CTRL_ABORT_EN
        // Abort in round 3, then a clean C.1 run
        @(negedge clk);
        o0 = out_q.size();
        send(C1_PT, C1_K);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("abort:in_ready",  128'(ifc.in_ready),  128'd1);
        check("abort:busy",      128'(busy),          128'd0);
        check("abort:out_valid", 128'(ifc.out_valid), 128'd0);
        check("abort:out_block", ifc.out_block,       128'd0);
        ifc.out_ready = 1'b1;
        repeat (14) @(negedge clk);
        ifc.out_ready = 1'b0;
        check("abort:no_out", 128'(out_q.size()), 128'(o0));
        txn(C1_PT, C1_K, C1_CT, 0, 1'b0, "abort_c1");
`endif

        // Randomized pairs against the whole-cipher reference
        for (int t = 0; t < 16; t++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            txn(pt, key, aes_ref(pt, key), int'($urandom_range(0, 4)),
                1'($urandom_range(0, 1)), $sformatf("rnd%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
